// File: rtl/vcc_wr_arbiter_pkg.sv
// Shared constants and types for the VCC write-back arbiter.
package vcc_wr_arbiter_pkg;

    localparam int NUM_SRC   = 8;
    localparam int WFID_W    = 6;
    localparam int VCC_W     = 64;
    localparam int SRC_IDX_W = 3;

    // Source indices: vector integer ALUs first, then vector float ALUs.
    localparam logic [SRC_IDX_W-1:0] SRC_SIMD0 = 3'd0;
    localparam logic [SRC_IDX_W-1:0] SRC_SIMD1 = 3'd1;
    localparam logic [SRC_IDX_W-1:0] SRC_SIMD2 = 3'd2;
    localparam logic [SRC_IDX_W-1:0] SRC_SIMD3 = 3'd3;
    localparam logic [SRC_IDX_W-1:0] SRC_SIMF0 = 3'd4;
    localparam logic [SRC_IDX_W-1:0] SRC_SIMF1 = 3'd5;
    localparam logic [SRC_IDX_W-1:0] SRC_SIMF2 = 3'd6;
    localparam logic [SRC_IDX_W-1:0] SRC_SIMF3 = 3'd7;

    localparam logic [SRC_IDX_W-1:0] LAST_SRC = SRC_IDX_W'(NUM_SRC - 1);

    // One queued VCC write-back.
    typedef struct packed {
        logic [WFID_W-1:0] wfid;
        logic [VCC_W-1:0]  value;
    } vcc_wr_t;

    // Round-robin successor of a source index, wrapping at NUM_SRC.
    function automatic logic [SRC_IDX_W-1:0] next_src(input logic [SRC_IDX_W-1:0] idx);
        if (idx == LAST_SRC) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/vcc_src_fifo.sv
// Per-source synchronous FIFO holding pending VCC write-backs.
// push is a one-cycle strobe: an entry is taken at the edge whenever the
// FIFO has room or is popped in the same cycle; otherwise it is dropped
// and the sticky overflow bit records the loss. pop is only honoured
// while the FIFO holds an entry; head is valid whenever empty is low.
module vcc_src_fifo
    import vcc_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  vcc_wr_t push_data,
    input  logic    pop,
    output vcc_wr_t head,
    output logic    full,
    output logic    empty,
    output logic    overflow
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    vcc_wr_t       mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/vcc_wr_arbiter.sv
// Merges VCC write-backs from the vector ALUs onto the single exec VCC
// write port. Each source queues into its own FIFO; one head is granted
// per cycle in round-robin order unless the SALU owns the port.
// exec_vcc_wr_en is a one-cycle strobe with no back-pressure: the exec
// block must accept every cycle it is high.
module vcc_wr_arbiter
    import vcc_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_vcc_wr_en,
    input  logic [NUM_SRC*WFID_W-1:0]   src_vcc_wr_wfid,
    input  logic [NUM_SRC*VCC_W-1:0]    src_vcc_wr_value,
    input  logic                        salu_wr_vcc_en,
    output logic [NUM_SRC-1:0]          src_full,
    output logic [NUM_SRC-1:0]          src_overflow,
    output logic                        exec_vcc_wr_en,
    output logic [WFID_W-1:0]           exec_vcc_wr_wfid,
    output logic [VCC_W-1:0]            exec_vcc_wr_value,
    output logic [SRC_IDX_W-1:0]        exec_vcc_wr_src
);

    logic [NUM_SRC-1:0]   src_empty;
    logic [NUM_SRC-1:0]   src_pop;
    vcc_wr_t              src_head [NUM_SRC];
    logic [SRC_IDX_W-1:0] rr_ptr;
    logic [SRC_IDX_W-1:0] grant_idx;
    logic [SRC_IDX_W-1:0] cand;
    logic                 grant_vld;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        vcc_wr_t push_entry;
        assign push_entry.wfid  = src_vcc_wr_wfid[i*WFID_W +: WFID_W];
        assign push_entry.value = src_vcc_wr_value[i*VCC_W +: VCC_W];

        vcc_src_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (src_vcc_wr_en[i]),
            .push_data(push_entry),
            .pop      (src_pop[i]),
            .head     (src_head[i]),
            .full     (src_full[i]),
            .empty    (src_empty[i]),
            .overflow (src_overflow[i])
        );
    end

    // Round-robin pick: scan from rr_ptr downwards in priority so the
    // closest non-empty source after rr_ptr overwrites any farther one.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        if (!salu_wr_vcc_en) begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                cand = SRC_IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
                if (!src_empty[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign src_pop = grant_vld ? (NUM_SRC'(1) << grant_idx) : '0;

    // Exec port registers and round-robin pointer advance on each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr            <= '0;
            exec_vcc_wr_en    <= 1'b0;
            exec_vcc_wr_wfid  <= '0;
            exec_vcc_wr_value <= '0;
            exec_vcc_wr_src   <= '0;
        end else begin
            exec_vcc_wr_en <= grant_vld;
            if (grant_vld) begin
                exec_vcc_wr_wfid  <= src_head[grant_idx].wfid;
                exec_vcc_wr_value <= src_head[grant_idx].value;
                exec_vcc_wr_src   <= grant_idx;
                rr_ptr            <= next_src(grant_idx);
            end
        end
    end

endmodule

// File: tb/tb_vcc_wr_arbiter.sv
// Directed bench for vcc_wr_arbiter: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand sequences for reset with
// pending entries and push-while-full-with-pop.
module tb_vcc_wr_arbiter;
    import vcc_wr_arbiter_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC-1:0]        src_vcc_wr_en;
    logic [NUM_SRC*WFID_W-1:0] src_vcc_wr_wfid;
    logic [NUM_SRC*VCC_W-1:0]  src_vcc_wr_value;
    logic                      salu_wr_vcc_en;
    logic [NUM_SRC-1:0]        src_full;
    logic [NUM_SRC-1:0]        src_overflow;
    logic                      exec_vcc_wr_en;
    logic [WFID_W-1:0]         exec_vcc_wr_wfid;
    logic [VCC_W-1:0]          exec_vcc_wr_value;
    logic [SRC_IDX_W-1:0]      exec_vcc_wr_src;

    always #5 clk = ~clk;

    vcc_wr_arbiter #(.DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .src_vcc_wr_en    (src_vcc_wr_en),
        .src_vcc_wr_wfid  (src_vcc_wr_wfid),
        .src_vcc_wr_value (src_vcc_wr_value),
        .salu_wr_vcc_en   (salu_wr_vcc_en),
        .src_full         (src_full),
        .src_overflow     (src_overflow),
        .exec_vcc_wr_en   (exec_vcc_wr_en),
        .exec_vcc_wr_wfid (exec_vcc_wr_wfid),
        .exec_vcc_wr_value(exec_vcc_wr_value),
        .exec_vcc_wr_src  (exec_vcc_wr_src)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  en;
        logic        salu;
        logic [5:0]  wb;        // source i gets wfid wb+i
        logic [63:0] vb;        // source i gets value vb+i
        logic        exp_en;
        logic        chk_data;
        logic [5:0]  exp_wfid;
        logic [63:0] exp_value;
        logic [2:0]  exp_src;
        logic [7:0]  exp_full;
        logic [7:0]  exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int   chk_total = 0;
    int   chk_pass  = 0;

    task automatic add(input logic [7:0] en, input logic salu, input logic [5:0] wb,
                       input logic [63:0] vb, input logic exp_en, input logic chk_data,
                       input logic [5:0] ew, input logic [63:0] ev, input logic [2:0] es,
                       input logic [7:0] ef, input logic [7:0] eo);
        vec_t v;
        v.en = en; v.salu = salu; v.wb = wb; v.vb = vb;
        v.exp_en = exp_en; v.chk_data = chk_data; v.exp_wfid = ew;
        v.exp_value = ev; v.exp_src = es; v.exp_full = ef; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] en, input logic [5:0] wb,
                         input logic [63:0] vb, input logic salu);
        src_vcc_wr_en  = en;
        salu_wr_vcc_en = salu;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_vcc_wr_wfid[i*WFID_W +: WFID_W] = wb + 6'(i);
            src_vcc_wr_value[i*VCC_W +: VCC_W]  = vb + 64'(i);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_total++;
        if (got === exp) begin
            chk_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic exp_en, input logic chk_data,
                              input logic [5:0] ew, input logic [63:0] ev, input logic [2:0] es,
                              input logic [7:0] ef, input logic [7:0] eo);
        check({tag, "_en"}, 64'(exec_vcc_wr_en), 64'(exp_en));
        check({tag, "_full"}, 64'(src_full), 64'(ef));
        check({tag, "_ovf"}, 64'(src_overflow), 64'(eo));
        if (chk_data) begin
            check({tag, "_wfid"}, 64'(exec_vcc_wr_wfid), 64'(ew));
            check({tag, "_value"}, exec_vcc_wr_value, ev);
            check({tag, "_src"}, 64'(exec_vcc_wr_src), 64'(es));
        end
    endtask

    // ---------------- test ----------------
    initial begin
        rst = 1'b1;
        drive(8'h00, 6'h0, 64'h0, 1'b0);
        step();
        step();
        check_outs("reset", 1'b0, 1'b1, 6'h0, 64'h0, 3'd0, 8'h00, 8'h00);
        rst = 1'b0;

        // All eight sources strobe together from rr_ptr=0.
        add(8'hFF, 0, 6'd0, 64'd16, 0, 1, 6'd0, 64'd0, 3'd0, 8'h00, 8'h00);
        for (int k = 0; k < 8; k++) begin
            add(8'h00, 0, 6'd0, 64'd0, 1, 1, 6'(k), 64'(k + 16), 3'(k), 8'h00, 8'h00);
        end
        add(8'h00, 0, 6'd0, 64'd0, 0, 1, 6'd7, 64'd23, 3'd7, 8'h00, 8'h00);
        // Single write on source 1: wfid 2, value 5.
        add(8'h02, 0, 6'd1, 64'd4, 0, 1, 6'd7, 64'd23, 3'd7, 8'h00, 8'h00);
        add(8'h00, 0, 6'd0, 64'd0, 1, 1, 6'd2, 64'd5, 3'd1, 8'h00, 8'h00);
        add(8'h00, 0, 6'd0, 64'd0, 0, 1, 6'd2, 64'd5, 3'd1, 8'h00, 8'h00);
        // Source 4 pending while the SALU owns the port for 3 cycles.
        add(8'h10, 0, 6'd5, 64'h3C, 0, 1, 6'd2, 64'd5, 3'd1, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            add(8'h00, 1, 6'd0, 64'd0, 0, 1, 6'd2, 64'd5, 3'd1, 8'h00, 8'h00);
        end
        add(8'h00, 0, 6'd0, 64'd0, 1, 1, 6'd9, 64'h40, 3'd4, 8'h00, 8'h00);
        // Source 3 strobes A, B, C under SALU hold; C overflows.
        add(8'h08, 1, 6'd7, 64'd7, 0, 1, 6'd9, 64'h40, 3'd4, 8'h00, 8'h00);
        add(8'h08, 1, 6'd8, 64'd8, 0, 1, 6'd9, 64'h40, 3'd4, 8'h08, 8'h00);
        add(8'h08, 1, 6'd9, 64'd9, 0, 1, 6'd9, 64'h40, 3'd4, 8'h08, 8'h08);
        add(8'h00, 0, 6'd0, 64'd0, 1, 1, 6'd10, 64'hA, 3'd3, 8'h00, 8'h08);
        add(8'h00, 0, 6'd0, 64'd0, 1, 1, 6'd11, 64'hB, 3'd3, 8'h00, 8'h08);
        add(8'h00, 0, 6'd0, 64'd0, 0, 1, 6'd11, 64'hB, 3'd3, 8'h00, 8'h08);
        // Sources 0 and 5 strobe whenever not full; grants alternate.
        add(8'h21, 0, 6'h20, 64'h100, 0, 1, 6'd11, 64'hB, 3'd3, 8'h00, 8'h08);
        add(8'h21, 0, 6'h21, 64'h200, 1, 1, 6'h25, 64'h105, 3'd5, 8'h01, 8'h08);
        add(8'h20, 0, 6'h22, 64'h300, 1, 1, 6'h20, 64'h100, 3'd0, 8'h20, 8'h08);
        add(8'h01, 0, 6'h23, 64'h400, 1, 1, 6'h26, 64'h205, 3'd5, 8'h01, 8'h08);
        add(8'h20, 0, 6'h24, 64'h500, 1, 1, 6'h21, 64'h200, 3'd0, 8'h20, 8'h08);
        add(8'h00, 0, 6'h00, 64'h000, 1, 1, 6'h27, 64'h305, 3'd5, 8'h00, 8'h08);
        // Build up entries on sources 2 and 6 ahead of a reset.
        add(8'h44, 1, 6'h30, 64'h600, 0, 1, 6'h27, 64'h305, 3'd5, 8'h00, 8'h08);
        add(8'h44, 1, 6'h31, 64'h700, 0, 1, 6'h27, 64'h305, 3'd5, 8'h44, 8'h08);

        foreach (vecs[r]) begin
            drive(vecs[r].en, vecs[r].wb, vecs[r].vb, vecs[r].salu);
            step();
            check_outs($sformatf("row%0d", r), vecs[r].exp_en, vecs[r].chk_data,
                       vecs[r].exp_wfid, vecs[r].exp_value, vecs[r].exp_src,
                       vecs[r].exp_full, vecs[r].exp_ovf);
        end

        // Reset with entries pending: everything clears, nothing drains.
        drive(8'h00, 6'h0, 64'h0, 1'b0);
        rst = 1'b1;
        step();
        check_outs("rst_pending", 1'b0, 1'b1, 6'h0, 64'h0, 3'd0, 8'h00, 8'h00);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check_outs($sformatf("post_rst%0d", k), 1'b0, 1'b1, 6'h0, 64'h0, 3'd0,
                       8'h00, 8'h00);
        end

        // Push into a full FIFO in the same cycle it is popped.
        drive(8'h04, 6'h10, 64'h1000, 1'b1);
        step();
        check_outs("pp_fill1", 1'b0, 1'b0, 6'h0, 64'h0, 3'd0, 8'h00, 8'h00);
        drive(8'h04, 6'h20, 64'h2000, 1'b1);
        step();
        check_outs("pp_fill2", 1'b0, 1'b0, 6'h0, 64'h0, 3'd0, 8'h04, 8'h00);
        drive(8'h04, 6'h30, 64'h3000, 1'b0);
        step();
        check_outs("pp_same", 1'b1, 1'b1, 6'h12, 64'h1002, 3'd2, 8'h04, 8'h00);
        drive(8'h00, 6'h0, 64'h0, 1'b0);
        step();
        check_outs("pp_drain1", 1'b1, 1'b1, 6'h22, 64'h2002, 3'd2, 8'h00, 8'h00);
        step();
        check_outs("pp_drain2", 1'b1, 1'b1, 6'h32, 64'h3002, 3'd2, 8'h00, 8'h00);
        step();
        check_outs("pp_idle", 1'b0, 1'b1, 6'h32, 64'h3002, 3'd2, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
